// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 5-stage IEEE-754-style float adder/subtractor with RNE, specials, flags and valid/ready
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    input  logic                 data_valid_in,
    output logic                 data_ready_out,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags,
    output logic                 data_valid_out,
    input  logic                 data_ready_in
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 4;
    localparam int EW = 14;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef struct packed {
        logic           sp;
        logic [W-1:0]   r;
        logic [3:0]     f;
        logic           s;
    } side_t;

    logic stall;
    logic [4:1] v_q;
    side_t side1;
    side_t side_q [1:4];
    assign stall = data_valid_out && !data_ready_in;
    assign data_ready_out = !stall;

    logic sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    assign {sa, ea, fa} = a;
    assign {eb, fb} = b[W-2:0];
    assign sb = b[W-1] ^ sub;
    assign a_nan = &ea && |fa;
    assign b_nan = &eb && |fb;
    assign a_inf = &ea && !(|fa);
    assign b_inf = &eb && !(|fb);
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_big = {ea, fa} >= {eb, fb};

    // Specials resolved up front and carried alongside the datapath to the final mux
    always_comb begin
        side1 = '0;
        side1.sp = 1'b1;
        side1.s = a_big ? sa : sb;
        if (a_nan || b_nan) begin
            side1.r = QNAN;
            side1.f = {(a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]), 3'b000};
        end else if (a_inf && b_inf && sa != sb) begin
            side1.r = QNAN;
            side1.f = 4'b1000;
        end else if (a_inf) side1.r = {sa, ea, fa};
        else if (b_inf) side1.r = {sb, eb, fb};
        else if (a_zero && b_zero) side1.r = {sa && sb, {(W-1){1'b0}}};
        else if (a_zero) side1.r = {sb, eb, fb};
        else if (b_zero) side1.r = {sa, ea, fa};
        else side1.sp = 1'b0;
    end

    logic sub1, sub2, z4;
    logic [EXP_W-1:0] e1b, e1s, e2, e3, d;
    logic [MAN_W:0] m1b, m1s;
    logic [AW-1:0] ext, al, al2b, al2s, n4, n4n;
    logic [AW:0] sum3;
    logic signed [EW-1:0] e4, e4n, er;
    int lz;

    assign d = e1b - e1s;
    assign ext = {m1s, 3'b000};
    assign al = int'(d) >= AW - 1 ? AW'(1) : (ext >> d) | AW'(|(ext & ~({AW{1'b1}} << d)));

    always_comb begin
        lz = AW;
        for (int i = 0; i < AW; i++) if (sum3[i]) lz = AW - 1 - i;
        n4n = sum3[AW] ? {sum3[AW:2], sum3[1] | sum3[0]} : sum3[AW-1:0] << lz;
        e4n = sum3[AW] ? EW'(e3) + EW'(1) : EW'(e3) - EW'(lz);
    end

    logic up;
    logic [MAN_W+1:0] mr;
    logic [W-1:0] r5;
    logic [3:0] f5;
    assign up = n4[2] && (n4[1] || n4[0] || n4[3]);
    assign mr = {1'b0, n4[AW-1:3]} + (MAN_W+2)'(up);
    assign er = e4 + EW'(mr[MAN_W+1]);
    assign {r5, f5} = side_q[4].sp ? {side_q[4].r, side_q[4].f}
                    : z4 ? '0
                    : er >= EMAX ? {side_q[4].s, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 4'b0101}
                    : er <= 0 ? {side_q[4].s, {(W-1){1'b0}}, 4'b0011}
                    : {side_q[4].s, er[EXP_W-1:0], (mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0]), 3'b000, |n4[2:0]};

    always_ff @(posedge clk_in) begin
        if (rst) begin
            v_q <= '0;
            data_valid_out <= 1'b0;
            result <= '0;
            flags <= '0;
        end else if (!stall) begin
            v_q <= {v_q[3:1], data_valid_in};
            data_valid_out <= v_q[4];
            if (v_q[4]) {result, flags} <= {r5, f5};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!stall) begin
            side_q[1] <= side1;
            for (int i = 2; i <= 4; i++) side_q[i] <= side_q[i-1];
            sub1 <= sa ^ sb;
            {e1b, m1b, e1s, m1s} <= a_big ? {ea, 1'b1, fa, eb, 1'b1, fb} : {eb, 1'b1, fb, ea, 1'b1, fa};
            sub2 <= sub1;
            e2 <= e1b;
            al2b <= {m1b, 3'b000};
            al2s <= al;
            e3 <= e2;
            sum3 <= sub2 ? {1'b0, al2b} - {1'b0, al2s} : {1'b0, al2b} + {1'b0, al2s};
            e4 <= e4n;
            n4 <= n4n;
            z4 <= ~|sum3;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed binary16 vectors plus backpressure and reset sequences
module tb_fp_addsub_pipe;
    logic clk_in = 1'b0;
    logic rst = 1'b1;
    logic [15:0] a = '0, b = '0, result;
    logic sub = 1'b0, data_valid_in = 1'b0, data_ready_in = 1'b1;
    logic data_ready_out, data_valid_out;
    logic [3:0] flags;
    int n_cmp = 0, n_bad = 0;

    fp_addsub_pipe dut (
        .clk_in(clk_in), .rst(rst), .a(a), .b(b), .sub(sub),
        .data_valid_in(data_valid_in), .data_ready_out(data_ready_out),
        .result(result), .flags(flags), .data_valid_out(data_valid_out),
        .data_ready_in(data_ready_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic [3:0]  f;
    } vec_t;
    vec_t tv [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                          output logic [15:0] r, output logic [3:0] f, output int lat);
        @(negedge clk_in);
        a = ia;
        b = ib;
        sub = isub;
        data_valid_in = 1'b1;
        @(posedge clk_in);
        lat = 1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        while (!data_valid_out && lat < 20) begin
            @(posedge clk_in);
            lat++;
            @(negedge clk_in);
        end
        r = result;
        f = flags;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] r, hr;
        logic [3:0] f, hf;
        int lat, sent, got;
        logic was_stall, acc, seen;
        tv[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'h0};
        tv[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'h0};
        tv[2]  = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 4'h0};
        tv[3]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'h1};
        tv[4]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'h1};
        tv[5]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5};
        tv[6]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'h8};
        tv[7]  = '{16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'h8};
        tv[8]  = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'h0};
        tv[9]  = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'h0};
        tv[10] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'h0};
        tv[11] = '{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 4'h0};
        tv[12] = '{16'h0001, 16'h3C00, 1'b0, 16'h3C00, 4'h0};
        tv[13] = '{16'h3C00, 16'h3800, 1'b1, 16'h3800, 4'h0};
        tv[14] = '{16'h4000, 16'hBC00, 1'b0, 16'h3C00, 4'h0};
        tv[15] = '{16'h8401, 16'h8400, 1'b1, 16'h8000, 4'h3};
        tv[16] = '{16'h3C00, 16'h0400, 1'b0, 16'h3C00, 4'h1};
        tv[17] = '{16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 4'h1};
        tv[18] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 4'h0};
        tv[19] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0};

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        chk("rst_valid", data_valid_out, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_ready", data_ready_out, 1);

        for (int i = 0; i < 20; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].sub, r, f, lat);
            chk($sformatf("vec%0d_result", i), r, tv[i].r);
            chk($sformatf("vec%0d_flags", i), f, tv[i].f);
            chk($sformatf("vec%0d_latency", i), lat, 5);
        end

        sent = 0;
        got = 0;
        was_stall = 1'b0;
        hr = '0;
        hf = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk_in);
            data_ready_in = !(cyc >= 6 && cyc <= 9);
            data_valid_in = sent < 8;
            if (sent < 8) begin
                a = tv[sent].a;
                b = tv[sent].b;
                sub = tv[sent].sub;
            end
            #1;
            if (was_stall) begin
                chk("bp_hold_valid", data_valid_out, 1);
                chk("bp_hold_result", result, hr);
                chk("bp_hold_flags", flags, hf);
            end
            was_stall = data_valid_out && !data_ready_in;
            if (was_stall) begin
                chk("bp_stall_ready", data_ready_out, 0);
                hr = result;
                hf = flags;
            end
            if (data_valid_out && data_ready_in) begin
                chk($sformatf("bp%0d_result", got), result, tv[got].r);
                chk($sformatf("bp%0d_flags", got), flags, tv[got].f);
                got++;
            end
            acc = data_valid_in && data_ready_out;
            @(posedge clk_in);
            if (acc) sent++;
        end
        @(negedge clk_in);
        data_valid_in = 1'b0;
        data_ready_in = 1'b1;
        chk("bp_received", got, 8);
        chk("bp_sent", sent, 8);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk_in);
            seen = seen | data_valid_out;
        end
        chk("bp_no_duplicate", seen, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            a = tv[i].a;
            b = tv[i].b;
            sub = tv[i].sub;
            data_valid_in = 1'b1;
        end
        @(negedge clk_in);
        data_valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        chk("midrst_valid", data_valid_out, 0);
        chk("midrst_ready", data_ready_out, 1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            seen = seen | data_valid_out;
        end
        chk("midrst_flushed", seen, 0);
        run_op(tv[13].a, tv[13].b, tv[13].sub, r, f, lat);
        chk("postrst_result", r, tv[13].r);
        chk("postrst_flags", f, tv[13].f);
        chk("postrst_latency", lat, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
